// File: rtl/strawman_rx_fsm.sv
// strawman_rx_fsm: rebuilds 1076-bit protocol packets from the 40-bit flit stream into a valid/ready output register.
// Optional mid-packet idle timeout is compiled in with STRAWMAN_RX_TIMEOUT_EN.
module strawman_rx_fsm #(
  parameter int DATA_LINE_WIDTH = 40,
  parameter int WORD_SIZE       = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_LINE_WIDTH-1:0] i_flit,
  input  logic                       i_flit_valid,
  output logic [1075:0]              o_protocol_bus,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_err,
  output logic                       o_overflow,
  output logic                       o_busy
);
  typedef enum logic [1:0] {IDLE, EX_ADDR, DATA, DONE} state_t;
  state_t r_state, w_next;
  logic r_mode, r_valid, r_err, r_ovf;
  logic [2:0] r_cmd, r_len;
  logic [31:0] r_addr;
  logic [1023:0] r_data;
  logic [5:0] r_f1, r_f2, r_cnt;
  logic [1075:0] r_bus;
  logic w_hdr, w_bad, w_last, w_load, w_tmo, w_err;
  if (DATA_LINE_WIDTH != 40 || WORD_SIZE != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("strawman_rx_fsm: unsupported parameter set");
  end
  assign w_hdr  = r_state == IDLE && i_flit_valid && i_flit[1];
  assign w_bad  = i_flit[4:2] > 3'd2 || i_flit[7:5] > 3'd5;
  assign w_last = r_cnt == (6'd1 << r_len) - 6'd1;
  assign w_load = r_state == DONE && (!r_valid || i_ready);
`ifdef STRAWMAN_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic w_wait;
  assign w_wait = r_state == EX_ADDR || r_state == DATA;
  assign w_tmo  = w_wait && !i_flit_valid && r_idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    r_idle <= (rst || i_flit_valid || !w_wait || w_tmo) ? '0 : r_idle + 1'b1;
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      IDLE:    if (w_hdr) begin
                 w_err  = w_bad;
                 w_next = w_bad ? IDLE :
                          (!i_flit[0] && i_flit[4:2] == 3'd0) ? DONE :
                          (i_flit[0] && i_flit[4:2] != 3'd2) ? EX_ADDR : DATA;
               end
      EX_ADDR: if (i_flit_valid) w_next = r_cmd == 3'd0 ? DONE : DATA;
      DATA:    if (i_flit_valid && w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (w_tmo) begin
      w_next = IDLE;
      w_err  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_mode, r_cmd, r_len, r_addr, r_data, r_f1, r_f2, r_cnt} <= '0;
      {r_bus, r_valid, r_err, r_ovf} <= '0;
    end else begin
      if (w_hdr && !w_bad) begin
        r_mode <= i_flit[0];
        r_cmd  <= i_flit[4:2];
        r_len  <= i_flit[7:5];
        r_addr <= (!i_flit[0] && i_flit[4:2] != 3'd2) ? i_flit[39:8] : 32'h0;
        r_f1   <= i_flit[0] ? i_flit[13:8] : 6'h0;
        r_f2   <= i_flit[0] ? i_flit[19:14] : 6'h0;
        r_data <= '0;
        r_cnt  <= '0;
      end
      if (r_state == EX_ADDR && i_flit_valid) r_addr <= i_flit[31:0];
      if (r_state == DATA && i_flit_valid) begin
        r_data[r_cnt[4:0] * WORD_SIZE +: WORD_SIZE] <= i_flit[WORD_SIZE-1:0];
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_load) r_bus <= {r_f2, r_f1, r_data, r_addr, r_len, r_cmd, 1'b1, r_mode};
      r_valid <= w_load || (r_valid && !i_ready);
      if (r_state == DONE && !w_load) r_ovf <= 1'b1;
      r_err <= w_err;
    end
  end
  assign o_protocol_bus = r_bus;
  assign o_valid        = r_valid;
  assign o_err          = r_err;
  assign o_overflow     = r_ovf;
  assign o_busy         = r_state != IDLE;
endmodule

// File: tb/tb_strawman_rx_fsm.sv
// tb_strawman_rx_fsm: directed and randomized packets checked against a field-level packet model and output-register model.
module tb_strawman_rx_fsm;
  logic clk = 1'b0;
  logic rst, i_flit_valid, i_ready, o_valid, o_err, o_overflow, o_busy;
  logic [39:0] i_flit;
  logic [1075:0] o_protocol_bus;
  int checks = 0, failures = 0;
  logic exp_valid = 1'b0, exp_ovf = 1'b0;
  logic [1075:0] exp_bus = '0;
  logic [31:0] words [32];

  strawman_rx_fsm dut (
    .clk(clk), .rst(rst), .i_flit(i_flit), .i_flit_valid(i_flit_valid),
    .o_protocol_bus(o_protocol_bus), .o_valid(o_valid), .i_ready(i_ready),
    .o_err(o_err), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag);
    logic [1087:0] ob, eb;
    int w;
    ob = {12'h0, o_protocol_bus};
    eb = {12'h0, exp_bus};
    w = 0;
    checks++;
    assert (o_protocol_bus === exp_bus) else begin
      failures++;
      for (int i = 33; i >= 0; i--) if (ob[i*32 +: 32] !== eb[i*32 +: 32]) w = i;
      $error("FAIL %s word%0d obs=%h exp=%h", tag, w, ob[w*32 +: 32], eb[w*32 +: 32]);
    end
  endtask

  // Output register model: applies the edge about to happen with the inputs now driven, then waits for the negedge.
  task automatic tick(input bit done, input logic [1075:0] pkt);
    if (done) begin
      if (!exp_valid || i_ready) begin
        exp_bus = pkt;
        exp_valid = 1'b1;
      end else exp_ovf = 1'b1;
    end else if (exp_valid && i_ready) exp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic put(input logic [39:0] f);
    i_flit = f;
    i_flit_valid = 1'b1;
    tick(1'b0, '0);
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(gmax, 0)) begin
      i_flit_valid = 1'b0;
      i_flit = {$urandom, $urandom};
      tick(1'b0, '0);
      chk("busy_in_gap", o_busy, 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_flit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_bus = '0;
    chk("rst_valid", o_valid, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk_bus("rst_bus");
  endtask

  task automatic send(input bit m, input logic [2:0] c, input logic [2:0] l, input logic [31:0] a,
                      input logic [5:0] f1, input logic [5:0] f2, input int gmax);
    logic [1075:0] e;
    e = '0;
    e[0] = m;
    e[1] = 1'b1;
    e[4:2] = c;
    e[7:5] = l;
    e[39:8] = (c == 3'd2) ? 32'h0 : a;
    if (m) begin
      e[1069:1064] = f1;
      e[1075:1070] = f2;
    end
    put({m ? {20'h0, f2, f1} : a, l, c, 1'b1, m});
    if (m && c != 3'd2) begin
      gap(gmax);
      put({8'($urandom), a});
    end
    if (c != 3'd0)
      for (int k = 0; k < (1 << l); k++) begin
        gap(gmax);
        put({8'($urandom), words[k]});
        e[40 + 32*k +: 32] = words[k];
      end
    chk("busy_done", o_busy, 1);
    chk("valid_before_load", o_valid, 64'(exp_valid));
    i_flit_valid = 1'b0;
    tick(1'b1, e);
    chk("valid_loaded", o_valid, 64'(exp_valid));
    chk("ovf", o_overflow, 64'(exp_ovf));
    chk("busy_idle", o_busy, 0);
    chk_bus("bus");
    tick(1'b0, '0);
    chk("valid_after", o_valid, 64'(exp_valid));
    chk_bus("bus_after");
  endtask

  initial begin
    i_flit = '0;
    i_flit_valid = 1'b0;
    i_ready = 1'b0;
    do_reset();
    i_ready = 1'b1;
    send(1'b0, 3'd0, 3'd0, 32'hDEADBEEF, 6'h0, 6'h0, 0);
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    send(1'b1, 3'd1, 3'd2, 32'h1000, 6'h15, 6'h2A, 0);
    for (int k = 0; k < 32; k++) words[k] = $urandom;
    send(1'b0, 3'd2, 3'd5, 32'hCAFEF00D, 6'h0, 6'h0, 1);
    // Illegal headers and a flit without the valid bit are all dropped in IDLE.
    put({32'h0, 3'd0, 3'd5, 1'b1, 1'b0});
    chk("err_cmd", o_err, 1);
    chk("err_cmd_busy", o_busy, 0);
    put({32'h0, 3'd7, 3'd1, 1'b1, 1'b0});
    chk("err_len", o_err, 1);
    chk("err_len_busy", o_busy, 0);
    put({32'h0, 3'd0, 3'd1, 1'b0, 1'b0});
    chk("nohdr_err", o_err, 0);
    chk("nohdr_busy", o_busy, 0);
    i_flit_valid = 1'b0;
    tick(1'b0, '0);
    chk("err_novalid", o_valid, 0);
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 32; k++) words[k] = $urandom;
      i_ready = ($urandom_range(3, 0) != 0);
      send(1'($urandom), 3'($urandom_range(2, 0)), 3'($urandom_range(5, 0)), $urandom,
           6'($urandom), 6'($urandom), 3);
    end
    i_ready = 1'b1;
    tick(1'b0, '0);
    chk("drain", o_valid, 0);
    do_reset();
    i_ready = 1'b0;
    words[0] = 32'hAAAA0001; words[1] = 32'hAAAA0002;
    send(1'b0, 3'd1, 3'd1, 32'h12345678, 6'h0, 6'h0, 0);
    words[0] = 32'hBBBB0001; words[1] = 32'hBBBB0002;
    send(1'b1, 3'd2, 3'd1, 32'h0, 6'h3, 6'h4, 0);
    chk("ovf_set", o_overflow, 1);
    chk("ovf_hold", o_valid, 1);
    do_reset();
    i_ready = 1'b1;
    put({32'h0, 3'd3, 3'd1, 1'b1, 1'b0});
    put(40'h1);
    put(40'h2);
    chk("mid_busy", o_busy, 1);
    do_reset();
`ifdef STRAWMAN_RX_TIMEOUT_EN
    put({32'h55, 3'd1, 3'd1, 1'b1, 1'b0});
    put(40'h77);
    i_flit_valid = 1'b0;
    repeat (63) tick(1'b0, '0);
    chk("tmo_wait_busy", o_busy, 1);
    chk("tmo_wait_err", o_err, 0);
    tick(1'b0, '0);
    chk("tmo_err", o_err, 1);
    chk("tmo_busy", o_busy, 0);
    tick(1'b0, '0);
    send(1'b0, 3'd0, 3'd0, 32'h0BADC0DE, 6'h0, 6'h0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
